// File: rtl/bira_pkg.sv
// bira_pkg: shared constants, state encoding and decode helpers for the BIRA controller.
// Consumers: bira_ctrl, bira_sol_packer.
package bira_pkg;

    localparam int unsigned PCAM         = 8;
    localparam int unsigned NPCAM        = 30;
    localparam int unsigned ADDR_W       = 10;
    localparam int unsigned BANK_W       = 2;
    localparam int unsigned PIDX_W       = 3;
    localparam int unsigned NIDX_W       = 5;
    localparam int unsigned SOL_W        = 16;

    localparam int unsigned SOL_ADDR_LSB = 0;
    localparam int unsigned SOL_BANK_LSB = 10;
    localparam int unsigned SOL_RC_BIT   = 12;
    localparam int unsigned SOL_IDX_LSB  = 13;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_FLUSH,
        ST_SEARCH,
        ST_CHECK,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Row/column spare counts are kept pre-decremented, matching the RLSS encoding.
    typedef struct packed {
        logic [1:0] rows_m1;
        logic [1:0] cols_m1;
        logic [3:0] total;
    } spare_cfg_t;

    function automatic spare_cfg_t decode_spares(input logic [1:0] ss);
        spare_cfg_t c;
        case (ss)
            2'b01:   c = '{rows_m1: 2'd2, cols_m1: 2'd2, total: 4'd6};
            2'b10:   c = '{rows_m1: 2'd3, cols_m1: 2'd3, total: 4'd8};
            default: c = '{rows_m1: 2'd1, cols_m1: 2'd1, total: 4'd4};
        endcase
        return c;
    endfunction

    function automatic logic [PCAM-1:0] used_mask(input logic [3:0] cnt);
        logic [PCAM:0] m;
        m = (9'd1 << cnt) - 9'd1;
        return m[PCAM-1:0];
    endfunction

    function automatic logic [PIDX_W-1:0] lowest_set(input logic [PCAM-1:0] v);
        logic [PIDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = PCAM; i > 0; i--) begin
            if (v[i-1]) idx = PIDX_W'(i - 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bira_sol_packer.sv
// bira_sol_packer: per-orientation spare usage counters and repair-solution word build.
module bira_sol_packer
    import bira_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              step,
    input  logic              rc,
    input  logic [BANK_W-1:0] bank,
    input  logic [ADDR_W-1:0] row,
    input  logic [ADDR_W-1:0] col,
    output logic [SOL_W-1:0]  word
);

    logic [2:0] row_used;
    logic [2:0] col_used;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_used <= '0;
            col_used <= '0;
        end else if (clr) begin
            row_used <= '0;
            col_used <= '0;
        end else if (step) begin
            if (rc) col_used <= col_used + 3'd1;
            else    row_used <= row_used + 3'd1;
        end
    end

    // The index field carries the spare number before this word consumes it.
    always_comb begin
        word = '0;
        word[SOL_IDX_LSB +: 3]       = rc ? col_used : row_used;
        word[SOL_RC_BIT]             = rc;
        word[SOL_BANK_LSB +: BANK_W] = bank;
        word[SOL_ADDR_LSB +: ADDR_W] = rc ? col : row;
    end

endmodule

// File: rtl/bira_ctrl.sv
// bira_ctrl: BIRA sequencer - fault classification, spare candidate search, solution emit.
// Build option BIRA_DUP_FILTER_EN drops faults whose row and column hit the same pivot.
module bira_ctrl
    import bira_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        spare_struct,
    input  logic              test_end,
    input  logic              fault_detect,
    input  logic [ADDR_W-1:0] row_add_in,
    input  logic [ADDR_W-1:0] col_add_in,
    input  logic [BANK_W-1:0] bank_in,
    input  logic [PCAM-1:0]   pcam_row_hit,
    input  logic [PCAM-1:0]   pcam_col_hit,
    input  logic [BANK_W-1:0] pv_bank,
    input  logic [ADDR_W-1:0] pv_row,
    input  logic [ADDR_W-1:0] pv_col,
    input  logic              signal_valid,
    output logic              pcam_wr,
    output logic [PIDX_W-1:0] pcam_idx,
    output logic              npcam_wr,
    output logic [NIDX_W-1:0] npcam_idx,
    output logic [PIDX_W-1:0] npcam_ptr,
    output logic [ADDR_W-1:0] wr_row,
    output logic [ADDR_W-1:0] wr_col,
    output logic [BANK_W-1:0] wr_bank,
    output logic [PIDX_W-1:0] pv_rd_idx,
    output logic [PCAM-1:0]   DSSS,
    output logic [3:0]        RLSS,
    output logic              early_term,
    output logic              repair,
    output logic              done,
    output logic              sol_valid,
    output logic [SOL_W-1:0]  solution
);

    state_t            state_q, state_d;
    spare_cfg_t        cfg;
    logic [3:0]        pcam_cnt;
    logic [NIDX_W-1:0] npcam_cnt;
    logic [PCAM-1:0]   cand;
    logic [PCAM-1:0]   mask;
    logic [PIDX_W-1:0] emit_idx;
    logic              emit_last;
    logic [PCAM-1:0]   byp_row, byp_col, row_hit, col_hit;
    logic              take_fault, any_hit, drop;
    logic              new_pivot, new_np, overflow, do_pwr, do_nwr;
    logic [SOL_W-1:0]  pack_word;

    // Fault classification; the entry being written this cycle is not yet in the CAM.
    always_comb begin
        cfg     = decode_spares(spare_struct);
        mask    = used_mask(pcam_cnt);
        byp_row = '0;
        byp_col = '0;
        if (pcam_wr) begin
            byp_row[pcam_idx] = (wr_row == row_add_in);
            byp_col[pcam_idx] = (wr_col == col_add_in);
        end
        row_hit    = pcam_row_hit | byp_row;
        col_hit    = pcam_col_hit | byp_col;
        any_hit    = |(row_hit | col_hit);
`ifdef BIRA_DUP_FILTER_EN
        drop       = |(row_hit & col_hit);
`else
        drop       = 1'b0;
`endif
        take_fault = (state_q == ST_COLLECT) && fault_detect;
        new_pivot  = take_fault && !any_hit;
        new_np     = take_fault && any_hit && !drop;
        overflow   = (new_pivot && (pcam_cnt == cfg.total)) ||
                     (new_np && (npcam_cnt == NIDX_W'(NPCAM)));
        do_pwr     = new_pivot && !overflow;
        do_nwr     = new_np && !overflow;
        emit_last  = ({1'b0, emit_idx} == (pcam_cnt - 4'd1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_COLLECT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: if (overflow)                state_d = ST_DONE;
                        else if (test_end)           state_d = ST_FLUSH;
            ST_FLUSH:   state_d = (pcam_cnt == '0) ? ST_DONE : ST_SEARCH;
            ST_SEARCH:  state_d = ST_CHECK;
            ST_CHECK:   if (signal_valid)            state_d = ST_EMIT;
                        else if (cand == mask)       state_d = ST_DONE;
                        else                         state_d = ST_SEARCH;
            ST_EMIT:    if (emit_last)               state_d = ST_DONE;
            default:    state_d = ST_DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcam_wr    <= 1'b0;
            npcam_wr   <= 1'b0;
            pcam_idx   <= '0;
            npcam_idx  <= '0;
            npcam_ptr  <= '0;
            wr_row     <= '0;
            wr_col     <= '0;
            wr_bank    <= '0;
            pcam_cnt   <= '0;
            npcam_cnt  <= '0;
            cand       <= '0;
            emit_idx   <= '0;
            early_term <= 1'b0;
            repair     <= 1'b0;
        end else begin
            pcam_wr  <= do_pwr;
            npcam_wr <= do_nwr;
            if (do_pwr) begin
                pcam_idx <= pcam_cnt[PIDX_W-1:0];
                pcam_cnt <= pcam_cnt + 4'd1;
            end
            if (do_nwr) begin
                npcam_idx <= npcam_cnt;
                npcam_ptr <= lowest_set(row_hit | col_hit);
                npcam_cnt <= npcam_cnt + 5'd1;
            end
            if (do_pwr || do_nwr) begin
                wr_row  <= row_add_in;
                wr_col  <= col_add_in;
                wr_bank <= bank_in;
            end
            case (state_q)
                ST_COLLECT: if (overflow) early_term <= 1'b1;
                ST_FLUSH: begin
                    cand <= '0;
                    if (pcam_cnt == '0) repair <= 1'b1;
                end
                ST_CHECK: begin
                    if (signal_valid)      emit_idx <= '0;
                    else if (cand != mask) cand     <= cand + 8'd1;
                end
                ST_EMIT: begin
                    if (emit_last) repair   <= 1'b1;
                    else           emit_idx <= emit_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

    bira_sol_packer u_packer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q != ST_EMIT),
        .step (state_q == ST_EMIT),
        .rc   (DSSS[emit_idx]),
        .bank (pv_bank),
        .row  (pv_row),
        .col  (pv_col),
        .word (pack_word)
    );

    always_comb begin
        done      = (state_q == ST_DONE);
        sol_valid = (state_q == ST_EMIT);
        pv_rd_idx = emit_idx;
        DSSS      = cand & mask;
        RLSS      = {cfg.rows_m1, cfg.cols_m1};
        solution  = sol_valid ? pack_word : '0;
    end

endmodule

// File: tb/tb_bira_ctrl.sv
// tb_bira_ctrl: scoreboard bench for bira_ctrl with a behavioural pivot CAM and validity checker.
module tb_bira_ctrl;
    import bira_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  spare_struct;
    logic        test_end, fault_detect;
    logic [9:0]  row_add_in, col_add_in;
    logic [1:0]  bank_in;
    logic [7:0]  pcam_row_hit, pcam_col_hit;
    logic [1:0]  pv_bank;
    logic [9:0]  pv_row, pv_col;
    logic        signal_valid;
    logic        pcam_wr, npcam_wr;
    logic [2:0]  pcam_idx, npcam_ptr, pv_rd_idx;
    logic [4:0]  npcam_idx;
    logic [9:0]  wr_row, wr_col;
    logic [1:0]  wr_bank;
    logic [7:0]  DSSS;
    logic [3:0]  RLSS;
    logic        early_term, repair, done, sol_valid;
    logic [15:0] solution;

    always #5 clk = ~clk;

    bira_ctrl dut (
        .clk(clk), .rst(rst), .spare_struct(spare_struct),
        .test_end(test_end), .fault_detect(fault_detect),
        .row_add_in(row_add_in), .col_add_in(col_add_in), .bank_in(bank_in),
        .pcam_row_hit(pcam_row_hit), .pcam_col_hit(pcam_col_hit),
        .pv_bank(pv_bank), .pv_row(pv_row), .pv_col(pv_col),
        .signal_valid(signal_valid),
        .pcam_wr(pcam_wr), .pcam_idx(pcam_idx), .npcam_wr(npcam_wr),
        .npcam_idx(npcam_idx), .npcam_ptr(npcam_ptr),
        .wr_row(wr_row), .wr_col(wr_col), .wr_bank(wr_bank),
        .pv_rd_idx(pv_rd_idx), .DSSS(DSSS), .RLSS(RLSS),
        .early_term(early_term), .repair(repair), .done(done),
        .sol_valid(sol_valid), .solution(solution)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          np_seen = 0;
    logic [30:0] wr_q[$];
    logic [15:0] sol_q[$];
    logic        sv_en = 1'b0;
    logic [7:0]  sv_target = 8'h00;

    // Pivot CAM and validity checker stand-ins
    logic [9:0] m_row[8];
    logic [9:0] m_col[8];
    logic [1:0] m_bank[8];
    logic [7:0] m_vld;

    always @(posedge clk or negedge rst) begin
        if (!rst) m_vld <= '0;
        else if (pcam_wr) begin
            m_vld[pcam_idx]  <= 1'b1;
            m_row[pcam_idx]  <= wr_row;
            m_col[pcam_idx]  <= wr_col;
            m_bank[pcam_idx] <= wr_bank;
        end
    end

    always_comb begin
        pcam_row_hit = '0;
        pcam_col_hit = '0;
        for (int i = 0; i < 8; i++) begin
            pcam_row_hit[i] = m_vld[i] && (m_row[i] == row_add_in);
            pcam_col_hit[i] = m_vld[i] && (m_col[i] == col_add_in);
        end
    end

    assign pv_row       = m_row[pv_rd_idx];
    assign pv_col       = m_col[pv_rd_idx];
    assign pv_bank      = m_bank[pv_rd_idx];
    assign signal_valid = sv_en && (DSSS == sv_target);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [30:0] wexp(input logic np, input logic [4:0] idx,
                                         input logic [2:0] ptr, input logic [1:0] b,
                                         input logic [9:0] r, input logic [9:0] c);
        return {np, idx, ptr, b, r, c};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (pcam_wr) begin
                if (wr_q.size() == 0) chk("pcam_wr-unexpected", 32'(pcam_wr), 32'd0);
                else chk("pcam-write", 32'({1'b0, 2'b00, pcam_idx, 3'b000, wr_bank, wr_row, wr_col}),
                         32'(wr_q.pop_front()));
            end
            if (npcam_wr) begin
                np_seen++;
                if (wr_q.size() == 0) chk("npcam_wr-unexpected", 32'(npcam_wr), 32'd0);
                else chk("npcam-write", 32'({1'b1, npcam_idx, npcam_ptr, wr_bank, wr_row, wr_col}),
                         32'(wr_q.pop_front()));
            end
            if (sol_valid) begin
                if (sol_q.size() == 0) chk("sol_valid-unexpected", 32'(sol_valid), 32'd0);
                else chk("solution", 32'(solution), 32'(sol_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fault(input logic [9:0] r, input logic [9:0] c, input logic [1:0] b);
        fault_detect = 1'b1;
        row_add_in   = r;
        col_add_in   = c;
        bank_in      = b;
        tick();
        fault_detect = 1'b0;
    endtask

    task automatic fault_p(input logic [9:0] r, input logic [9:0] c, input logic [1:0] b,
                           input logic [2:0] idx);
        wr_q.push_back(wexp(1'b0, {2'b00, idx}, 3'd0, b, r, c));
        fault(r, c, b);
    endtask

    task automatic fault_n(input logic [9:0] r, input logic [9:0] c, input logic [1:0] b,
                           input logic [4:0] idx, input logic [2:0] ptr);
        wr_q.push_back(wexp(1'b1, idx, ptr, b, r, c));
        fault(r, c, b);
    endtask

    task automatic end_test();
        test_end = 1'b1;
        tick();
        test_end = 1'b0;
    endtask

    task automatic apply_reset();
        fault_detect = 1'b0;
        test_end     = 1'b0;
        sv_en        = 1'b0;
        rst          = 1'b0;
        #1;
        wr_q.delete();
        sol_q.delete();
        np_seen = 0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic drained(input string tag);
        chk({tag, "-writes-left"}, 32'(wr_q.size()), 32'd0);
        chk({tag, "-words-left"}, 32'(sol_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    logic [3:0] rlss_tab[4];

    initial begin
        spare_struct = 2'b00;
        test_end     = 1'b0;
        fault_detect = 1'b0;
        row_add_in   = '0;
        col_add_in   = '0;
        bank_in      = '0;
        rlss_tab     = '{4'h5, 4'hA, 4'hF, 4'h5};

        #2 rst = 1'b0;
        tick();
        chk("rst-pcam_wr", 32'(pcam_wr), 0);
        chk("rst-npcam_wr", 32'(npcam_wr), 0);
        chk("rst-DSSS", 32'(DSSS), 0);
        chk("rst-flags", 32'({early_term, repair, done, sol_valid}), 0);
        chk("rst-solution", 32'(solution), 0);
        for (int s = 0; s < 4; s++) begin
            spare_struct = 2'(s);
            #1 chk("RLSS", 32'(RLSS), 32'(rlss_tab[s]));
        end
        spare_struct = 2'b00;
        rst = 1'b1;
        tick();

        // No faults: repair with nothing to emit
        end_test();
        wait_done(5, "nofault-done");
        chk("nofault-repair", 32'(repair), 1);

        // Pivots 0/1, bypassed non-pivot, solution at cand 0
        apply_reset();
        sv_en = 1'b1;
        sv_target = 8'h00;
        sol_q.push_back({3'd0, 1'b0, 2'd1, 10'd5});
        sol_q.push_back({3'd1, 1'b0, 2'd2, 10'd12});
        fault_p(10'd5, 10'd7, 2'd1, 3'd0);
        fault_n(10'd5, 10'd9, 2'd1, 5'd0, 3'd0);
        fault_p(10'd12, 10'd3, 2'd2, 3'd1);
        end_test();
        wait_done(20, "t1-done");
        chk("t1-repair", 32'(repair), 1);
        chk("t1-early", 32'(early_term), 0);
        fault(10'd40, 10'd41, 2'd0);
        end_test();
        chk("t1-done-held", 32'(done), 1);
        drained("t1");

        // Early termination on the fifth pivot with 2R2C
        apply_reset();
        for (int i = 0; i < 4; i++) fault_p(10'(i + 1), 10'(i + 1), 2'd0, 3'(i));
        fault(10'd5, 10'd5, 2'd0);
        chk("t2-early", 32'(early_term), 1);
        chk("t2-done", 32'(done), 1);
        chk("t2-repair", 32'(repair), 0);
        chk("t2-no-write", 32'(pcam_wr), 0);
        tick();
        drained("t2");

        // Back-to-back bypass then duplicate fault
        apply_reset();
        sv_en = 1'b1;
        sv_target = 8'h01;
        fault_p(10'd3, 10'd4, 2'd0, 3'd0);
        fault_n(10'd3, 10'd8, 2'd0, 5'd0, 3'd0);
        tick();
`ifdef BIRA_DUP_FILTER_EN
        fault(10'd3, 10'd4, 2'd0);
        tick();
        chk("t3-np-count", 32'(np_seen), 1);
`else
        fault_n(10'd3, 10'd4, 2'd0, 5'd1, 3'd0);
        tick();
        chk("t3-np-count", 32'(np_seen), 2);
`endif
        sol_q.push_back({3'd0, 1'b1, 2'd0, 10'd4});
        end_test();
        wait_done(20, "t3-done");
        chk("t3-repair", 32'(repair), 1);
        drained("t3");

        // Exhaustive search failure with 3 pivots, spare_struct 11 as 2R2C
        apply_reset();
        spare_struct = 2'b11;
        fault_p(10'd1, 10'd1, 2'd3, 3'd0);
        fault_p(10'd2, 10'd2, 2'd3, 3'd1);
        fault_p(10'd3, 10'd3, 2'd3, 3'd2);
        end_test();
        repeat (16) tick();
        chk("t4-done-early", 32'(done), 0);
        chk("t4-last-cand", 32'(DSSS), 32'h07);
        tick();
        chk("t4-done", 32'(done), 1);
        chk("t4-repair", 32'(repair), 0);
        chk("t4-early", 32'(early_term), 0);
        drained("t4");

        // Mixed row/column solution, 4R4C
        apply_reset();
        spare_struct = 2'b10;
        sv_en = 1'b1;
        sv_target = 8'h05;
        sol_q.push_back({3'd0, 1'b1, 2'd1, 10'd20});
        sol_q.push_back({3'd0, 1'b0, 2'd2, 10'd11});
        sol_q.push_back({3'd1, 1'b1, 2'd3, 10'd22});
        fault_p(10'd10, 10'd20, 2'd1, 3'd0);
        fault_p(10'd11, 10'd21, 2'd2, 3'd1);
        fault_p(10'd12, 10'd22, 2'd3, 3'd2);
        end_test();
        wait_done(30, "t5-done");
        chk("t5-repair", 32'(repair), 1);
        chk("t5-DSSS", 32'(DSSS), 32'h05);
        drained("t5");

        // Reset pulse during EMIT
        apply_reset();
        spare_struct = 2'b00;
        sv_en = 1'b1;
        sv_target = 8'h00;
        sol_q.push_back({3'd0, 1'b0, 2'd1, 10'd6});
        fault_p(10'd6, 10'd6, 2'd1, 3'd0);
        fault_p(10'd7, 10'd7, 2'd2, 3'd1);
        end_test();
        for (int n = 0; n < 20 && !sol_valid; n++) tick();
        chk("t6-emit-reached", 32'(sol_valid), 1);
        tick();
        rst = 1'b0;
        #1;
        chk("t6-rst-sol_valid", 32'(sol_valid), 0);
        chk("t6-rst-solution", 32'(solution), 0);
        chk("t6-rst-flags", 32'({early_term, repair, done}), 0);
        chk("t6-rst-DSSS", 32'(DSSS), 0);
        drained("t6");
        tick();
        rst = 1'b1;
        sv_en = 1'b0;
        tick();
        fault_p(10'd9, 10'd9, 2'd0, 3'd0);
        tick();
        chk("t6-collect-done", 32'(done), 0);
        drained("t6-post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bira_ctrl.md
# bira_ctrl

Sequencing controller for the BIRA datapath. During test it classifies each BIST fault as a pivot or non-pivot and issues write strobes into the pivot CAM (8 entries) and the non-pivot CAM (30 entries), raising early termination when the spares cannot cover the fault set. After `test_end` it walks the row/column spare-selection candidates through the signal validity checker. It then streams the repair solution out one 16-bit word per cycle.

## Interface
- `PCAM`, 8, pivot CAM depth; also the width of the DSSS candidate
- `NPCAM`, 30, non-pivot CAM depth
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  asynchronous, active-low reset
- `spare_struct`  in  2  spare config: 00 = 2R2C, 01 = 3R3C, 10 = 4R4C, 11 = treated as 00
- `test_end`, `fault_detect`  in  1 each  from BIST
- `row_add_in`, `col_add_in`  in  10 each  fault address
- `bank_in`  in  2  fault bank
- `pcam_row_hit`, `pcam_col_hit`  in  PCAM each  combinational CAM compare of the current address, valid entries only
- `pv_bank`  in  2  pivot entry read data for `pv_rd_idx`, combinational
- `pv_row`, `pv_col`  in  10 each  pivot entry read data for `pv_rd_idx`, combinational
- `signal_valid`  in  1  validity checker result for the current DSSS/RLSS
- `pcam_wr`  out  1  pivot CAM write strobe
- `pcam_idx`  out  3  pivot CAM write index
- `npcam_wr`  out  1  non-pivot CAM write strobe
- `npcam_idx`  out  5  non-pivot CAM write index
- `npcam_ptr`  out  3  pivot index the non-pivot points to
- `wr_row`, `wr_col`  out  10 each  registered write data
- `wr_bank`  out  2  registered write data
- `pv_rd_idx`  out  3  pivot read index
- `DSSS`  out  8  candidate; bit i = 1 means column repair for pivot i
- `RLSS`  out  4  `{row_spares[1:0], col_spares[1:0]}` minus 1 each
- `early_term`, `repair`, `done`, `sol_valid`  out  1 each
- `solution`  out  16  `{idx[2:0], rc, bank[1:0], addr[9:0]}`

## Operation
- States: COLLECT → FLUSH → SEARCH ↔ CHECK → EMIT → DONE. Reset enters COLLECT.
- COLLECT, when `fault_detect` is 1:
  - The hit vectors are ORed with a bypass compare against the entry being written this cycle.
  - No row or column hit: new pivot at `pcam_cnt`, counter incremented.
  - Any hit: non-pivot at `npcam_cnt`, `npcam_ptr` = lowest hit index.
- Early termination:
  - Condition: a new pivot arrives when `pcam_cnt` equals the spare total (4/6/8), or a non-pivot arrives when `npcam_cnt` = NPCAM.
  - Action: `early_term` = 1 (sticky), `repair` = 0, go to DONE, no write.
- `test_end` in COLLECT moves to FLUSH, even if a fault arrives the same cycle; that fault is still written. FLUSH lasts one cycle, then SEARCH with `cand` = 0.
- `pcam_cnt` = 0 at FLUSH: go to DONE with `repair` = 1 and no solution words.
- SEARCH drives `DSSS` = `cand` masked to used pivots. CHECK samples `signal_valid`:
  - 1: go to EMIT.
  - 0 with `cand` = 2^`pcam_cnt` − 1: go to DONE, `repair` = 0.
  - Otherwise: `cand` + 1, back to SEARCH.
- EMIT, for i = 0..`pcam_cnt`−1, one word per cycle:
  - `sol_valid` = 1, `pv_rd_idx` = i.
  - `solution` = {running count of spares used of that orientation, DSSS[i], `pv_bank`, `pv_col` if column else `pv_row`}.
  - Then go to DONE, `repair` = 1.
- DONE holds all outputs until reset. Further `fault_detect`/`test_end` are ignored.

## Timing
- Reset values: all strobes 0, counters 0, `DSSS` 0, `early_term`/`repair`/`done`/`sol_valid` 0, `solution` 0. `RLSS` is the combinational decode.
- Write strobe and data are registered: visible 1 cycle after `fault_detect`. Back-to-back faults are accepted every cycle; the bypass covers the 1-cycle gap.
- Each candidate takes 2 cycles. Worst-case search is 2·256 cycles.
- `done` rises in the cycle DONE is entered.
- Reset asserted mid-operation clears all state immediately. CAM contents are owned by the CAMs.

## Configuration
- `BIRA_DUP_FILTER_EN`: a fault whose row and column both hit the same pivot is dropped, with no write and no count change.
- Without the macro, such a fault is stored as a non-pivot.

## Structure
- `bira_pkg` holds:
  - PCAM/NPCAM constants and the state enum.
  - The `spare_struct` → row/column/total decode function.
  - Solution field offsets.
- One sub-module, `bira_sol_packer`: per-orientation spare counters and the 16-bit word build for EMIT.

## Test plan
- 2R2C; faults (5,7), (5,9), (12,3) then `test_end`:
  - Required: pivots at indices 0 and 1, non-pivot ptr = 0.
  - Then `signal_valid` = 1 at cand 0: two words, `repair` = 1.
- 2R2C, 5 faults with distinct rows and columns: `early_term` = 1 the cycle after the 5th fault, no write, DONE.
- Back-to-back (3,4) then (3,8) on consecutive cycles: second is a non-pivot via bypass, ptr = 0.
- `signal_valid` tied 0 with 3 pivots: 8 candidates tried over 16 cycles, then `repair` = 0, `done` = 1.
- Reset pulse during EMIT: all outputs return to 0 within the same cycle; state returns to COLLECT.
- Duplicate fault (3,4) twice: with the macro, `npcam_cnt` stays 0; without it, `npcam_cnt` = 1.
